// File: rtl/axi_w_burst_buffer.sv
// W-channel burst buffer: FIFO of {user, strb, data, last} beats with optional
// store-and-forward release that falls back to cut-through when a burst overflows.
module axi_w_burst_buffer #(
  parameter int DATA_WIDTH        = 64,
  parameter int USER_WIDTH        = 1,
  parameter int BUFFER_DEPTH      = 8,
  parameter int STORE_AND_FORWARD = 0,
  parameter int STRB_WIDTH        = DATA_WIDTH / 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  test_en_i,
  input  logic                                  slave_valid_i,
  output logic                                  slave_ready_o,
  input  logic [DATA_WIDTH-1:0]                 slave_data_i,
  input  logic [STRB_WIDTH-1:0]                 slave_strb_i,
  input  logic [USER_WIDTH-1:0]                 slave_user_i,
  input  logic                                  slave_last_i,
  output logic                                  master_valid_o,
  input  logic                                  master_ready_i,
  output logic [DATA_WIDTH-1:0]                 master_data_o,
  output logic [STRB_WIDTH-1:0]                 master_strb_o,
  output logic [USER_WIDTH-1:0]                 master_user_o,
  output logic                                  master_last_o,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]     fill_o,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]     bursts_o,
  output logic                                  err_o
);

  localparam int  CW  = $clog2(BUFFER_DEPTH + 1);
  localparam int  PW  = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int  EW  = USER_WIDTH + STRB_WIDTH + DATA_WIDTH + 1;
  localparam bit  SAF = (STORE_AND_FORWARD != 0);

  if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("axi_w_burst_buffer: DATA_WIDTH must be a multiple of 8 and at least 8");
  end
  if (USER_WIDTH < 1) begin : g_bad_user_width
    $error("axi_w_burst_buffer: USER_WIDTH must be at least 1");
  end
  if (BUFFER_DEPTH < 2) begin : g_bad_depth
    $error("axi_w_burst_buffer: BUFFER_DEPTH must be at least 2");
  end
  if (STRB_WIDTH != DATA_WIDTH / 8) begin : g_bad_strb_width
    $error("axi_w_burst_buffer: STRB_WIDTH is derived from DATA_WIDTH and must not be overridden");
  end

  logic [EW-1:0] mem [BUFFER_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fill_q, bursts_q;
  logic          force_q, err_q;
  logic          push, pop, push_last, pop_last;
  logic          force_cond, force_act;
  logic          unused_test_en;

  assign unused_test_en = test_en_i;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUFFER_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Force releases a burst that can never complete inside a full buffer.
  assign force_cond = SAF && (fill_q == CW'(BUFFER_DEPTH)) && (bursts_q == '0);
  assign force_act  = force_q | force_cond;

  assign slave_ready_o  = rst_ni & (fill_q != CW'(BUFFER_DEPTH));
  assign master_valid_o = (fill_q != '0) & (!SAF | (bursts_q != '0) | force_act);

  assign push      = slave_valid_i & slave_ready_o;
  assign pop       = master_valid_o & master_ready_i;
  assign push_last = push & slave_last_i;
  assign pop_last  = pop & master_last_o;

  assign {master_user_o, master_strb_o, master_data_o, master_last_o} = mem[rd_ptr];

  assign fill_o   = fill_q;
  assign bursts_o = bursts_q;
  assign err_o    = err_q | force_cond;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {slave_user_i, slave_strb_i, slave_data_i, slave_last_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_q   <= '0;
      bursts_q <= '0;
      force_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);

      if (push && !pop)      fill_q <= fill_q + CW'(1);
      else if (pop && !push) fill_q <= fill_q - CW'(1);

      if (push_last && !pop_last)      bursts_q <= bursts_q + CW'(1);
      else if (pop_last && !push_last) bursts_q <= bursts_q - CW'(1);

      // Held until the tail of the released burst leaves, so it drains in cut-through.
      if (pop_last)        force_q <= 1'b0;
      else if (force_cond) force_q <= 1'b1;

      if (force_cond) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_w_burst_buffer.sv
// Directed bench: one cut-through and one store-and-forward instance, depth 4,
// 32-bit data, hand-computed expectations checked with immediate assertions.
module tb_axi_w_burst_buffer;

  localparam int DW = 32;
  localparam int SW = 4;
  localparam int UW = 1;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          ct_sv, ct_sr, ct_sl, ct_mv, ct_mr, ct_ml, ct_err;
  logic [DW-1:0] ct_sd, ct_md;
  logic [SW-1:0] ct_ss, ct_ms;
  logic [UW-1:0] ct_su, ct_mu;
  logic [CW-1:0] ct_fill, ct_bursts;

  logic          sf_sv, sf_sr, sf_sl, sf_mv, sf_mr, sf_ml, sf_err;
  logic [DW-1:0] sf_sd, sf_md;
  logic [SW-1:0] sf_ss, sf_ms;
  logic [UW-1:0] sf_su, sf_mu;
  logic [CW-1:0] sf_fill, sf_bursts;

  int n_cmp = 0;
  int n_err = 0;

  axi_w_burst_buffer #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .BUFFER_DEPTH(D), .STORE_AND_FORWARD(0)) u_ct (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b0),
    .slave_valid_i(ct_sv), .slave_ready_o(ct_sr), .slave_data_i(ct_sd), .slave_strb_i(ct_ss),
    .slave_user_i(ct_su), .slave_last_i(ct_sl),
    .master_valid_o(ct_mv), .master_ready_i(ct_mr), .master_data_o(ct_md), .master_strb_o(ct_ms),
    .master_user_o(ct_mu), .master_last_o(ct_ml),
    .fill_o(ct_fill), .bursts_o(ct_bursts), .err_o(ct_err));

  axi_w_burst_buffer #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .BUFFER_DEPTH(D), .STORE_AND_FORWARD(1)) u_sf (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(1'b1),
    .slave_valid_i(sf_sv), .slave_ready_o(sf_sr), .slave_data_i(sf_sd), .slave_strb_i(sf_ss),
    .slave_user_i(sf_su), .slave_last_i(sf_sl),
    .master_valid_o(sf_mv), .master_ready_i(sf_mr), .master_data_o(sf_md), .master_strb_o(sf_ms),
    .master_user_o(sf_mu), .master_last_o(sf_ml),
    .fill_o(sf_fill), .bursts_o(sf_bursts), .err_o(sf_err));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    ct_sv = 0; ct_sd = '0; ct_ss = '0; ct_su = '0; ct_sl = 0; ct_mr = 0;
    sf_sv = 0; sf_sd = '0; sf_ss = '0; sf_su = '0; sf_sl = 0; sf_mr = 0;

    // reset state
    step(); step();
    chk("rst_ct_ready", ct_sr, 0);
    chk("rst_ct_valid", ct_mv, 0);
    chk("rst_ct_fill", ct_fill, 0);
    chk("rst_sf_bursts", sf_bursts, 0);
    chk("rst_sf_err", sf_err, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ct_ready", ct_sr, 1);
    chk("post_rst_sf_ready", sf_sr, 1);
    step();

    // cut-through single beat
    ct_sv = 1; ct_sd = 32'hA5A50001; ct_ss = 4'hF; ct_su = 1'b1; ct_sl = 1;
    step();
    ct_sv = 0;
    chk("ct1_valid", ct_mv, 1);
    chk("ct1_data", ct_md, 32'hA5A50001);
    chk("ct1_strb", ct_ms, 4'hF);
    chk("ct1_user", ct_mu, 1);
    chk("ct1_last", ct_ml, 1);
    chk("ct1_fill", ct_fill, 1);
    chk("ct1_bursts", ct_bursts, 1);
    ct_mr = 1;
    step();
    ct_mr = 0;
    chk("ct1_drained_fill", ct_fill, 0);
    chk("ct1_drained_valid", ct_mv, 0);

    // full: four beats, fifth held, one pop reopens
    for (int i = 0; i < 4; i++) begin
      ct_sv = 1; ct_sd = 32'h100 + i; ct_ss = 4'(i + 1); ct_su = 1'(i); ct_sl = (i == 3);
      step();
    end
    chk("full_ready", ct_sr, 0);
    chk("full_fill", ct_fill, 4);
    chk("full_bursts", ct_bursts, 1);
    ct_sd = 32'h104; ct_ss = 4'h5; ct_su = 1'b0; ct_sl = 1;
    step();
    chk("full_held_fill", ct_fill, 4);
    chk("full_held_ready", ct_sr, 0);
    ct_mr = 1;
    step();
    ct_mr = 0;
    chk("after_pop_ready", ct_sr, 1);
    chk("after_pop_fill", ct_fill, 3);
    chk("after_pop_head", ct_md, 32'h101);
    chk("after_pop_strb", ct_ms, 4'h2);
    step();
    ct_sv = 0;
    chk("fifth_acc_fill", ct_fill, 4);
    chk("fifth_acc_bursts", ct_bursts, 2);
    ct_mr = 1;
    for (int i = 1; i < 5; i++) begin
      chk("drain_valid", ct_mv, 1);
      chk("drain_data", ct_md, 32'h100 + i);
      step();
    end
    ct_mr = 0;
    chk("drain_fill", ct_fill, 0);
    chk("drain_bursts", ct_bursts, 0);
    chk("ct_err_never", ct_err, 0);

    // simultaneous push(last) and pop(last) at fill 2
    ct_sv = 1; ct_sd = 32'h200; ct_sl = 1;
    step();
    ct_sd = 32'h201; ct_sl = 0;
    step();
    chk("sim_pre_fill", ct_fill, 2);
    chk("sim_pre_bursts", ct_bursts, 1);
    ct_sd = 32'h202; ct_sl = 1; ct_mr = 1;
    step();
    ct_sv = 0; ct_mr = 0;
    chk("sim_fill", ct_fill, 2);
    chk("sim_bursts", ct_bursts, 1);
    chk("sim_head", ct_md, 32'h201);
    ct_mr = 1;
    step(); step();
    ct_mr = 0;
    chk("sim_drain_fill", ct_fill, 0);
    chk("sim_drain_bursts", ct_bursts, 0);

    // store-and-forward: three-beat burst held until its last beat arrives
    sf_mr = 1;
    sf_sv = 1; sf_sd = 32'h300; sf_ss = 4'h1; sf_sl = 0;
    step();
    chk("saf_b1_valid", sf_mv, 0);
    chk("saf_b1_fill", sf_fill, 1);
    sf_sd = 32'h301;
    step();
    chk("saf_b2_valid", sf_mv, 0);
    sf_sd = 32'h302; sf_sl = 1;
    step();
    sf_sv = 0;
    chk("saf_rel_valid", sf_mv, 1);
    chk("saf_rel_data0", sf_md, 32'h300);
    chk("saf_rel_bursts", sf_bursts, 1);
    step();
    chk("saf_data1", sf_md, 32'h301);
    chk("saf_fill1", sf_fill, 2);
    step();
    chk("saf_data2", sf_md, 32'h302);
    chk("saf_last2", sf_ml, 1);
    chk("saf_bursts_before_last", sf_bursts, 1);
    step();
    chk("saf_bursts_after_last", sf_bursts, 0);
    chk("saf_end_valid", sf_mv, 0);
    chk("saf_no_err", sf_err, 0);
    sf_mr = 0;

    // store-and-forward overflow: five-beat burst forced out
    for (int i = 0; i < 4; i++) begin
      sf_sv = 1; sf_sd = 32'h400 + i; sf_sl = 0;
      step();
    end
    sf_sd = 32'h404; sf_sl = 1; sf_mr = 1;
    chk("ovf_err", sf_err, 1);
    chk("ovf_valid", sf_mv, 1);
    chk("ovf_fill", sf_fill, 4);
    chk("ovf_head", sf_md, 32'h400);
    step();
    chk("ovf_d1", sf_md, 32'h401);
    chk("ovf_valid_held", sf_mv, 1);
    chk("ovf_fill3", sf_fill, 3);
    step();
    sf_sv = 0;
    chk("ovf_d2", sf_md, 32'h402);
    chk("ovf_fill_pp", sf_fill, 3);
    step();
    chk("ovf_d3", sf_md, 32'h403);
    step();
    chk("ovf_d4", sf_md, 32'h404);
    chk("ovf_d4_last", sf_ml, 1);
    step();
    sf_mr = 0;
    chk("ovf_end_fill", sf_fill, 0);
    chk("ovf_end_valid", sf_mv, 0);
    chk("ovf_err_sticky", sf_err, 1);

    // reset mid-burst
    ct_sv = 1; ct_sd = 32'h500; ct_sl = 0;
    step();
    ct_sd = 32'h501;
    step();
    ct_sv = 0;
    chk("mid_fill", ct_fill, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", ct_mv, 0);
    chk("mid_rst_fill", ct_fill, 0);
    chk("mid_rst_bursts", ct_bursts, 0);
    chk("mid_rst_ready", ct_sr, 0);
    chk("mid_rst_sf_err", sf_err, 0);
    step();
    rst_n = 1'b1;
    step();
    ct_sv = 1; ct_sd = 32'h600; ct_ss = 4'hA; ct_sl = 1;
    step();
    ct_sv = 0;
    chk("post_rst_valid", ct_mv, 1);
    chk("post_rst_data", ct_md, 32'h600);
    chk("post_rst_fill", ct_fill, 1);
    chk("post_rst_sf_err", sf_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_w_burst_buffer.md
AXI_W_BURST_BUFFER -- requirements
Module: axi_w_burst_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: W data width in bits; multiple of 8, at least 8.
REQ-002 SHALL have parameter USER_WIDTH, default 1: W user width in bits; at least 1.
REQ-003 SHALL have parameter BUFFER_DEPTH, default 8: number of W beats stored; at least 2.
REQ-004 SHALL have parameter STORE_AND_FORWARD, default 0: 1 = forward only complete bursts; 0 = cut-through.
REQ-005 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8: derived, never overridden.
REQ-006 SHALL have ports:
  clk_i  in  1  clock, all state on rising edge
  rst_ni  in  1  reset, asynchronous, active-low
  test_en_i  in  1  DFT enable; no functional effect
  slave_valid_i / slave_ready_o  in/out  1/1  upstream handshake
  slave_data_i / slave_strb_i / slave_user_i / slave_last_i  in  DATA_WIDTH / STRB_WIDTH / USER_WIDTH / 1  upstream payload
  master_valid_o / master_ready_i  out/in  1/1  downstream handshake
  master_data_o / master_strb_o / master_user_o / master_last_o  out  same widths  downstream payload
  fill_o  out  $clog2(BUFFER_DEPTH+1)  beats stored
  bursts_o  out  $clog2(BUFFER_DEPTH+1)  complete bursts stored (last beat stored)
  err_o  out  1  sticky store-and-forward overflow flag
REQ-007 SHALL reject illegal parameters (REQ-001..003) with an elaboration-time error.

Function
REQ-008 SHALL store beats in a FIFO; each entry holds {user, strb, data, last}; order is preserved bit-exact.
REQ-009 Push: slave_valid_i & slave_ready_o at a rising edge; pop: master_valid_o & master_ready_i at a rising edge.
REQ-010 slave_ready_o SHALL be 1 iff fill_o < BUFFER_DEPTH and rst_ni = 1; no combinational path from master_ready_i.
REQ-011 When full, a pop and a push in the same cycle SHALL NOT occur (ready is 0); after a pop, ready rises the next cycle.
REQ-012 Latency: a beat pushed at edge N SHALL be presentable on master outputs from edge N onward (visible in cycle N+1); no combinational slave-to-master path.
REQ-013 Cut-through (STORE_AND_FORWARD=0): master_valid_o = (fill_o != 0).
REQ-014 Store-and-forward: master_valid_o = (fill_o != 0) & ((bursts_o != 0) | force), where force = (fill_o == BUFFER_DEPTH) & (bursts_o == 0).
REQ-015 Once force is asserted, it SHALL persist until a beat with last=1 has been popped, so a partly released burst completes in cut-through.
REQ-016 err_o SHALL be set on the first cycle force asserts and hold until reset; never set when STORE_AND_FORWARD=0.
REQ-017 Once master_valid_o = 1, master_valid_o and the payload SHALL stay stable until the pop.
REQ-018 Payload outputs SHALL be the FIFO head entry; their value is unspecified while master_valid_o = 0.
REQ-019 fill_o: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-020 bursts_o: +1 on push with slave_last_i=1, -1 on pop with master_last_o=1, unchanged when both or neither.
REQ-021 Read/write pointers SHALL wrap from BUFFER_DEPTH-1 to 0, including when BUFFER_DEPTH is not a power of two.
REQ-022 Push while empty and pop of a different beat in the same cycle SHALL be impossible; bypass from input to output is not provided.

Reset
REQ-023 While rst_ni = 0: master_valid_o = 0, slave_ready_o = 0, fill_o = 0, bursts_o = 0, err_o = 0, force = 0, pointers = 0, immediately, without a clock edge.
REQ-024 Reset mid-operation SHALL discard all stored beats; FIFO storage is not reset.
REQ-025 In the first cycle after rst_ni rises, slave_ready_o SHALL be 1.

Verification (DATA_WIDTH=32, USER_WIDTH=1, BUFFER_DEPTH=4)
REQ-026 Cut-through, single beat: push data 0xA5A50001, strb 0xF, last 1 at edge 0 -> master_valid_o = 1 in cycle 1 with identical payload; fill_o = 1, bursts_o = 1.
REQ-027 Full: master_ready_i = 0, push 4 beats -> slave_ready_o = 0, fill_o = 4; a 5th valid beat is held. One pop -> slave_ready_o = 1 next cycle, and the 5th beat is accepted.
REQ-028 Store-and-forward: push 3 beats, last on the 3rd -> master_valid_o stays 0 until the cycle after the 3rd push, then delivers 3 beats in order; bursts_o goes 1 to 0 on the last pop.
REQ-029 Store-and-forward overflow: 5-beat burst -> at fill 4, err_o = 1 and master_valid_o = 1; all 5 beats are delivered in order; err_o stays 1.
REQ-030 Simultaneous push(last=1) and pop(last=1) at fill 2 -> fill_o = 2, bursts_o unchanged.
REQ-031 Reset mid-burst: 2 beats stored, rst_ni low -> master_valid_o = 0, fill_o = 0, bursts_o = 0, err_o = 0 in the same cycle; after release, the first pushed beat is the first popped.
